ub_port_arbiter: RTL and testbench

UB_PORT_ARBITER -- requirements
Module: ub_port_arbiter

---
 rtl/tpu_package.sv | 13 +
 rtl/ub_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_ub_port_arbiter.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tpu_package.sv
// rtl/tpu_package.sv - shared TPU sizing constants and unified-buffer owner encoding
package tpu_package;

  localparam int MUL_SIZE = 4;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    COMP = 2'd1,
    WB   = 2'd2,
    HOST = 2'd3
  } owner_e;

endpackage

// File: rtl/ub_port_arbiter.sv
// rtl/ub_port_arbiter.sv - single-port unified buffer arbiter for compute reads, writeback and host DMA
module ub_port_arbiter
  import tpu_package::*;
#(
  parameter int STARVE_LIMIT = 16,
  parameter int UB_ADDR_W    = 12,
  parameter int UB_DATA_W    = MUL_SIZE * 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 comp_req_i,
  input  logic [UB_ADDR_W-1:0] comp_addr_i,
  input  logic [7:0]           comp_len_i,
  input  logic                 wb_req_i,
  input  logic [UB_ADDR_W-1:0] wb_addr_i,
  input  logic [7:0]           wb_len_i,
  input  logic [UB_DATA_W-1:0] wb_data_i,
  input  logic                 host_req_i,
  input  logic [UB_ADDR_W-1:0] host_addr_i,
  input  logic [7:0]           host_len_i,
  input  logic [UB_DATA_W-1:0] host_data_i,
  output logic                 comp_gnt_o,
  output logic                 wb_gnt_o,
  output logic                 host_gnt_o,
  output logic                 comp_rd_valid_o,
  output logic                 ub_en_o,
  output logic                 ub_we_o,
  output logic [UB_ADDR_W-1:0] ub_addr_o,
  output logic [UB_DATA_W-1:0] ub_wdata_o,
  output logic [1:0]           owner_o,
  output logic                 busy_o
);

  localparam logic [4:0] WAIT_MAX = 5'd31;

  // A starving writer outranks compute; rr (0 = wb, 1 = host) splits writer ties.
  function automatic owner_e pick_winner(input logic comp_r, input logic wb_r,
                                         input logic host_r, input logic wb_s,
                                         input logic host_s, input logic rr);
    owner_e win;
    win = NONE;
    if ((wb_r && wb_s) && (host_r && host_s)) win = rr ? HOST : WB;
    else if (wb_r && wb_s)                    win = WB;
    else if (host_r && host_s)                win = HOST;
    else if (comp_r)                          win = COMP;
    else if (wb_r && host_r)                  win = rr ? HOST : WB;
    else if (wb_r)                            win = WB;
    else if (host_r)                          win = HOST;
    return win;
  endfunction

  owner_e               state_q, state_d;
  logic [UB_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]           left_q, left_d;
  logic                 rr_q, rr_d;
  logic [4:0]           wb_wait_q, wb_wait_d;
  logic [4:0]           host_wait_q, host_wait_d;
  logic                 rd_valid_q, rd_valid_d;

  logic   busy;
  logic   arb;
  owner_e win;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    left_d     = left_q;
    rr_d       = rr_q;
    busy       = (state_q != NONE);
    arb        = !busy || (left_q == 8'd0);
    rd_valid_d = (state_q == COMP);

    // The current owner is masked so it cannot re-win its own boundary.
    win = pick_winner(comp_req_i && (state_q != COMP),
                      wb_req_i && (state_q != WB),
                      host_req_i && (state_q != HOST),
                      32'(wb_wait_q) >= STARVE_LIMIT,
                      32'(host_wait_q) >= STARVE_LIMIT,
                      rr_q);

    if (busy) begin
      addr_d = addr_q + 1'b1;
      left_d = left_q - 8'd1;
    end

    if (arb) begin
      state_d = win;
      case (win)
        COMP: begin
          addr_d = comp_addr_i;
          left_d = comp_len_i;
        end
        WB: begin
          addr_d = wb_addr_i;
          left_d = wb_len_i;
          rr_d   = 1'b1;
        end
        HOST: begin
          addr_d = host_addr_i;
          left_d = host_len_i;
          rr_d   = 1'b0;
        end
        default: begin
          addr_d = '0;
          left_d = '0;
        end
      endcase
    end

    if (!wb_req_i || state_q == WB) wb_wait_d = '0;
    else if (wb_wait_q == WAIT_MAX)  wb_wait_d = wb_wait_q;
    else                             wb_wait_d = wb_wait_q + 5'd1;

    if (!host_req_i || state_q == HOST) host_wait_d = '0;
    else if (host_wait_q == WAIT_MAX)    host_wait_d = host_wait_q;
    else                                 host_wait_d = host_wait_q + 5'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= NONE;
      addr_q      <= '0;
      left_q      <= '0;
      rr_q        <= 1'b0;
      wb_wait_q   <= '0;
      host_wait_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      left_q      <= left_d;
      rr_q        <= rr_d;
      wb_wait_q   <= wb_wait_d;
      host_wait_q <= host_wait_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign comp_gnt_o      = (state_q == COMP);
  assign wb_gnt_o        = (state_q == WB);
  assign host_gnt_o      = (state_q == HOST);
  assign comp_rd_valid_o = rd_valid_q;
  assign ub_en_o         = busy;
  assign ub_we_o         = (state_q == WB) || (state_q == HOST);
  assign ub_addr_o       = busy ? addr_q : '0;
  assign ub_wdata_o      = (state_q == WB)   ? wb_data_i :
                           (state_q == HOST) ? host_data_i : '0;
  assign owner_o         = state_q;
  assign busy_o          = busy;

endmodule

// File: tb/tb_ub_port_arbiter.sv
// tb/tb_ub_port_arbiter.sv - directed self-checking bench for ub_port_arbiter
module tb_ub_port_arbiter;

  localparam int AW = 12;
  localparam int DW = tpu_package::MUL_SIZE * 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          comp_req_i, wb_req_i, host_req_i;
  logic [AW-1:0] comp_addr_i, wb_addr_i, host_addr_i;
  logic [7:0]    comp_len_i, wb_len_i, host_len_i;
  logic [DW-1:0] wb_data_i, host_data_i;
  logic          comp_gnt_o, wb_gnt_o, host_gnt_o, comp_rd_valid_o;
  logic          ub_en_o, ub_we_o, busy_o;
  logic [AW-1:0] ub_addr_o;
  logic [DW-1:0] ub_wdata_o;
  logic [1:0]    owner_o;

  int checks = 0;
  int errors = 0;

  ub_port_arbiter #(.STARVE_LIMIT(16), .UB_ADDR_W(AW), .UB_DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .comp_req_i(comp_req_i), .comp_addr_i(comp_addr_i), .comp_len_i(comp_len_i),
    .wb_req_i(wb_req_i), .wb_addr_i(wb_addr_i), .wb_len_i(wb_len_i), .wb_data_i(wb_data_i),
    .host_req_i(host_req_i), .host_addr_i(host_addr_i), .host_len_i(host_len_i),
    .host_data_i(host_data_i),
    .comp_gnt_o(comp_gnt_o), .wb_gnt_o(wb_gnt_o), .host_gnt_o(host_gnt_o),
    .comp_rd_valid_o(comp_rd_valid_o),
    .ub_en_o(ub_en_o), .ub_we_o(ub_we_o), .ub_addr_o(ub_addr_o), .ub_wdata_o(ub_wdata_o),
    .owner_o(owner_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i      = 1'b1;
    comp_req_i = 1'b0; wb_req_i = 1'b0; host_req_i = 1'b0;
    comp_addr_i = '0; wb_addr_i = '0; host_addr_i = '0;
    comp_len_i = '0; wb_len_i = '0; host_len_i = '0;
    wb_data_i = '0; host_data_i = '0;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_owner"}, 32'(owner_o), 32'd0);
    check({tag, "_en"}, 32'(ub_en_o), 32'd0);
    check({tag, "_we"}, 32'(ub_we_o), 32'd0);
    check({tag, "_addr"}, 32'(ub_addr_o), 32'd0);
    check({tag, "_wdata"}, 32'(ub_wdata_o), 32'd0);
    check({tag, "_gnts"}, {29'd0, comp_gnt_o, wb_gnt_o, host_gnt_o}, 32'd0);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  int lens[4]  = '{2, 15, 16, 19};
  int first[4] = '{1, 1, 2, 2};

  initial begin
    do_reset();
    check_idle("rst");
    check("rst_rdv", 32'(comp_rd_valid_o), 32'd0);

    // Lone compute burst: 4 beats from 0x010, read valid one cycle behind each beat.
    comp_req_i = 1'b1; comp_addr_i = 12'h010; comp_len_i = 8'd3;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("comp_gnt", 32'(comp_gnt_o), 32'd1);
      check("comp_addr", 32'(ub_addr_o), 32'h010 + 32'(k - 1));
      check("comp_we", 32'(ub_we_o), 32'd0);
      check("comp_rdv", 32'(comp_rd_valid_o), (k >= 2) ? 32'd1 : 32'd0);
      comp_req_i = 1'b0;
    end
    tick();
    check_idle("comp_end");
    check("comp_rdv_tail", 32'(comp_rd_valid_o), 32'd1);
    tick();
    check("comp_rdv_off", 32'(comp_rd_valid_o), 32'd0);

    // Simultaneous comp and wb with zero wait: comp first, wb straight after.
    do_reset();
    comp_req_i = 1'b1; comp_addr_i = 12'h100; comp_len_i = 8'd1;
    wb_req_i = 1'b1; wb_addr_i = 12'h200; wb_len_i = 8'd1;
    tick();
    check("cw_c1", 32'(owner_o), 32'd1);
    comp_req_i = 1'b0;
    tick();
    check("cw_c2", 32'(owner_o), 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("cw_wb_owner", 32'(owner_o), 32'd2);
      check("cw_wb_addr", 32'(ub_addr_o), 32'h200 + 32'(k));
      check("cw_wb_we", 32'(ub_we_o), 32'd1);
      wb_data_i = 32'hC0DE_0000 + 32'(k);
      #1;
      check("cw_wb_wdata", 32'(ub_wdata_o), 32'hC0DE_0000 + 32'(k));
      wb_req_i = 1'b0;
    end
    tick();
    check("cw_end", 32'(owner_o), 32'd0);

    // Writer round-robin: wb, host, idle, wb, host.
    do_reset();
    wb_addr_i = 12'h300; host_addr_i = 12'h400;
    wb_req_i = 1'b1; host_req_i = 1'b1;
    tick(); check("rr_1", 32'(owner_o), 32'd2); wb_req_i = 1'b0;
    tick(); check("rr_2", 32'(owner_o), 32'd3); host_req_i = 1'b0;
    tick(); check("rr_3", 32'(owner_o), 32'd0); wb_req_i = 1'b1; host_req_i = 1'b1;
    tick(); check("rr_4", 32'(owner_o), 32'd2); wb_req_i = 1'b0;
    tick(); check("rr_5", 32'(owner_o), 32'd3); host_req_i = 1'b0;
    tick(); check("rr_6", 32'(owner_o), 32'd0);

    // Host burst wrapping past the top of the address space.
    do_reset();
    host_req_i = 1'b1; host_addr_i = 12'hFFE; host_len_i = 8'd3;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wrap_owner", 32'(owner_o), 32'd3);
      check("wrap_we", 32'(ub_we_o), 32'd1);
      check("wrap_addr", 32'(ub_addr_o), (32'hFFE + 32'(k)) & 32'hFFF);
      host_data_i = 32'hA5A5_0000 + 32'(k);
      #1;
      check("wrap_wdata", 32'(ub_wdata_o), 32'hA5A5_0000 + 32'(k));
      host_req_i = 1'b0;
    end
    tick();
    check_idle("wrap_end");

    // Reset on the 2nd beat of an 8-beat wb burst.
    do_reset();
    wb_req_i = 1'b1; wb_addr_i = 12'h050; wb_len_i = 8'd7;
    tick(); check("abort_b1", 32'(ub_addr_o), 32'h050); wb_req_i = 1'b0;
    tick(); check("abort_b2", 32'(ub_addr_o), 32'h051);
    rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    check_idle("abort_rst");
    tick(); check_idle("abort_after");

    // Reset during a compute burst suppresses the trailing read valid.
    do_reset();
    comp_req_i = 1'b1; comp_addr_i = 12'h020; comp_len_i = 8'd3;
    tick(); check("crst_gnt", 32'(comp_gnt_o), 32'd1); comp_req_i = 1'b0;
    rst_i = 1'b1;
    tick(); rst_i = 1'b0;
    check("crst_rdv", 32'(comp_rd_valid_o), 32'd0);

    // Continuous compute with wb waiting through a long burst.
    do_reset();
    comp_req_i = 1'b1; comp_addr_i = 12'h700; comp_len_i = 8'd19;
    wb_req_i = 1'b1; wb_addr_i = 12'h800; wb_len_i = 8'd0;
    repeat (20) tick();
    check("starve_c20", 32'(owner_o), 32'd1);
    tick();
    check("starve_wb", 32'(owner_o), 32'd2);
    check("starve_wb_addr", 32'(ub_addr_o), 32'h800);
    wb_req_i = 1'b0;
    tick();
    check("starve_comp", 32'(owner_o), 32'd1);
    check("starve_comp_addr", 32'(ub_addr_o), 32'h700);
    comp_req_i = 1'b0;

    // Starvation threshold while host owns the port: wb wins over comp once wait >= 16.
    for (int t = 0; t < 4; t++) begin
      do_reset();
      host_req_i = 1'b1; host_addr_i = 12'h600; host_len_i = 8'(lens[t]);
      comp_addr_i = 12'h700; comp_len_i = 8'd0;
      wb_addr_i = 12'h800; wb_len_i = 8'd0;
      tick();
      host_req_i = 1'b0; comp_req_i = 1'b1; wb_req_i = 1'b1;
      repeat (lens[t]) tick();
      check("thr_last", 32'(owner_o), 32'd3);
      tick();
      check($sformatf("thr_first_len%0d", lens[t]), 32'(owner_o), 32'(first[t]));
      if (first[t] == 2) wb_req_i = 1'b0;
      else               comp_req_i = 1'b0;
      tick();
      check($sformatf("thr_second_len%0d", lens[t]), 32'(owner_o), 32'(3 - first[t]));
      comp_req_i = 1'b0; wb_req_i = 1'b0;
      tick();
      check("thr_idle", 32'(owner_o), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
